cpu_trace_lockstep_cmp: RTL and testbench

//  Parametrised lockstep checker between the reference CPU and the DUV CPU. Each side

---
 rtl/cpu_trace_lockstep_cmp_if.sv | 13 +
 rtl/cpu_trace_lockstep_cmp.sv | 160 ++++++++++++++++
 tb/tb_cpu_trace_lockstep_cmp.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_lockstep_cmp_if.sv
// rtl/cpu_trace_lockstep_cmp_if.sv - retire-trace push bus shared by reference and DUV sides
interface cpu_trace_lockstep_cmp_if #(
   parameter int NUM_CH = 6,
   parameter int DATA_W = 16
);
   logic                     ref_vld;
   logic [NUM_CH*DATA_W-1:0] ref_data;
   logic                     duv_vld;
   logic [NUM_CH*DATA_W-1:0] duv_data;

   modport master (output ref_vld, ref_data, duv_vld, duv_data);
   modport slave  (input  ref_vld, ref_data, duv_vld, duv_data);
endinterface

// File: rtl/cpu_trace_lockstep_cmp.sv
// rtl/cpu_trace_lockstep_cmp.sv - lockstep retire-trace checker with skew FIFOs
// Pairs ref/DUV records in retire order, compares under a channel mask, flags and captures errors.
module cpu_trace_lockstep_cmp #(
   parameter int NUM_CH       = 6,
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 8,
   parameter int MAX_SKEW     = 64,
   parameter int CNT_W        = 32,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_clr,
   input  logic [NUM_CH-1:0]          i_ch_mask,
   cpu_trace_lockstep_cmp_if.slave    i_trace,
   output logic [CNT_W-1:0]           o_cmp_count,
   output logic [CNT_W-1:0]           o_mism_count,
   output logic                       o_err_mismatch,
   output logic                       o_err_timeout,
   output logic                       o_err_overflow,
   output logic [CNT_W-1:0]           o_fail_idx,
   output logic [NUM_CH-1:0]          o_fail_ch,
   output logic [NUM_CH*DATA_W-1:0]   o_fail_ref,
   output logic [NUM_CH*DATA_W-1:0]   o_fail_duv,
   output logic                       o_halted
);
   localparam int REC_W = NUM_CH * DATA_W;
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   state_t              r_state;
   logic [REC_W-1:0]    r_ref_mem [DEPTH];
   logic [REC_W-1:0]    r_duv_mem [DEPTH];
   logic [PTR_W:0]      r_ref_wp, r_ref_rp, r_duv_wp, r_duv_rp;
   logic [CNT_W-1:0]    r_skew, r_cmp_count, r_mism_count, r_fail_idx;
   logic                r_err_mismatch, r_err_timeout, r_err_overflow;
   logic [NUM_CH-1:0]   r_fail_ch;
   logic [REC_W-1:0]    r_fail_ref, r_fail_duv;

   logic                w_active, w_pop, w_mism, w_ovf, w_tmo, w_err_evt;
   logic                w_ref_empty, w_duv_empty, w_ref_full, w_duv_full;
   logic                w_ref_push_req, w_duv_push_req, w_ref_push, w_duv_push;
   logic                w_skew_inc;
   logic [CNT_W-1:0]    w_skew_next;
   logic [REC_W-1:0]    w_ref_head, w_duv_head;
   logic [NUM_CH-1:0]   w_diff;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_ref_empty = (r_ref_wp == r_ref_rp);
   assign w_duv_empty = (r_duv_wp == r_duv_rp);
   assign w_ref_full  = (r_ref_wp[PTR_W] != r_ref_rp[PTR_W]) &&
                        (r_ref_wp[PTR_W-1:0] == r_ref_rp[PTR_W-1:0]);
   assign w_duv_full  = (r_duv_wp[PTR_W] != r_duv_rp[PTR_W]) &&
                        (r_duv_wp[PTR_W-1:0] == r_duv_rp[PTR_W-1:0]);

   assign w_active       = (r_state == ST_RUN) && i_en;
   assign w_pop          = w_active && !w_ref_empty && !w_duv_empty;
   assign w_ref_push_req = w_active && i_trace.ref_vld;
   assign w_duv_push_req = w_active && i_trace.duv_vld;
   assign w_ref_push     = w_ref_push_req && (!w_ref_full || w_pop);
   assign w_duv_push     = w_duv_push_req && (!w_duv_full || w_pop);
   assign w_ovf          = (w_ref_push_req && !w_ref_push) || (w_duv_push_req && !w_duv_push);

   assign w_ref_head = r_ref_mem[r_ref_rp[PTR_W-1:0]];
   assign w_duv_head = r_duv_mem[r_duv_rp[PTR_W-1:0]];

   always_comb begin
      w_diff = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_diff[k] = i_ch_mask[k] && (w_ref_head[k*DATA_W +: DATA_W] != w_duv_head[k*DATA_W +: DATA_W]);
      end
   end

   assign w_mism     = w_pop && (w_diff != '0);
   assign w_skew_inc = w_active && !w_pop && (w_ref_empty != w_duv_empty);

   always_comb begin
      w_skew_next = r_skew;
      if (w_pop || (w_ref_empty && w_duv_empty)) begin
         w_skew_next = '0;
      end else if (w_skew_inc && (r_skew != '1)) begin
         w_skew_next = r_skew + 1'b1;
      end
   end

   assign w_tmo     = w_skew_inc && (w_skew_next >= CNT_W'(MAX_SKEW));
   assign w_err_evt = w_mism || w_ovf || w_tmo;

   always_ff @(posedge i_clk) begin
      if (w_ref_push) r_ref_mem[r_ref_wp[PTR_W-1:0]] <= i_trace.ref_data;
      if (w_duv_push) r_duv_mem[r_duv_wp[PTR_W-1:0]] <= i_trace.duv_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_state        <= ST_IDLE;
         r_ref_wp       <= '0;
         r_ref_rp       <= '0;
         r_duv_wp       <= '0;
         r_duv_rp       <= '0;
         r_skew         <= '0;
         r_cmp_count    <= '0;
         r_mism_count   <= '0;
         r_err_mismatch <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_err_overflow <= 1'b0;
         r_fail_idx     <= '0;
         r_fail_ch      <= '0;
         r_fail_ref     <= '0;
         r_fail_duv     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_en) r_state <= ST_RUN;
            ST_RUN: begin
               if (!i_en) r_state <= ST_IDLE;
               else if (w_err_evt && (STOP_ON_FAIL != 0)) r_state <= ST_HALT;
            end
            default: r_state <= ST_HALT;
         endcase

         if (w_ref_push) r_ref_wp <= r_ref_wp + 1'b1;
         if (w_duv_push) r_duv_wp <= r_duv_wp + 1'b1;

         if (w_pop) begin
            r_ref_rp <= r_ref_rp + 1'b1;
            r_duv_rp <= r_duv_rp + 1'b1;
            if (r_cmp_count != '1) r_cmp_count <= r_cmp_count + 1'b1;
         end

         // Capture only the first mismatch; r_err_mismatch doubles as the "already captured" marker.
         if (w_mism) begin
            r_err_mismatch <= 1'b1;
            if (r_mism_count != '1) r_mism_count <= r_mism_count + 1'b1;
            if (!r_err_mismatch) begin
               r_fail_idx <= r_cmp_count;
               r_fail_ch  <= w_diff;
               r_fail_ref <= w_ref_head;
               r_fail_duv <= w_duv_head;
            end
         end

         if (w_active) r_skew <= w_skew_next;
         if (w_ovf) r_err_overflow <= 1'b1;
         if (w_tmo) r_err_timeout  <= 1'b1;
      end
   end

   assign o_cmp_count    = r_cmp_count;
   assign o_mism_count   = r_mism_count;
   assign o_err_mismatch = r_err_mismatch;
   assign o_err_timeout  = r_err_timeout;
   assign o_err_overflow = r_err_overflow;
   assign o_fail_idx     = r_fail_idx;
   assign o_fail_ch      = r_fail_ch;
   assign o_fail_ref     = r_fail_ref;
   assign o_fail_duv     = r_fail_duv;
   assign o_halted       = (r_state == ST_HALT);
endmodule

// File: tb/tb_cpu_trace_lockstep_cmp.sv
// tb/tb_cpu_trace_lockstep_cmp.sv - self-checking bench for cpu_trace_lockstep_cmp
// Drives a halting and a non-halting checker from one trace bus; expectations come from a pairwise record model.
module tb_cpu_trace_lockstep_cmp;
   localparam int NUM_CH   = 6;
   localparam int DATA_W   = 16;
   localparam int DEPTH    = 8;
   localparam int MAX_SKEW = 64;
   localparam int CNT_W    = 32;
   localparam int REC_W    = NUM_CH * DATA_W;
   localparam int ALL_W    = 3*CNT_W + 4 + NUM_CH + 2*REC_W;

   logic clk = 1'b0;
   logic rst, en, clr;
   logic [NUM_CH-1:0] mask;
   always #5 clk = ~clk;

   cpu_trace_lockstep_cmp_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) trace_if ();

   logic [CNT_W-1:0] hx_cmp, hx_mism, hx_fidx, rx_cmp, rx_mism, rx_fidx;
   logic hx_emm, hx_eto, hx_eov, hx_halted, rx_emm, rx_eto, rx_eov, rx_halted;
   logic [NUM_CH-1:0] hx_fch, rx_fch;
   logic [REC_W-1:0] hx_fref, hx_fduv, rx_fref, rx_fduv;
   logic [ALL_W-1:0] hx_all, rx_all;
   assign hx_all = {hx_cmp, hx_mism, hx_emm, hx_eto, hx_eov, hx_fidx, hx_fch, hx_fref, hx_fduv, hx_halted};
   assign rx_all = {rx_cmp, rx_mism, rx_emm, rx_eto, rx_eov, rx_fidx, rx_fch, rx_fref, rx_fduv, rx_halted};

   cpu_trace_lockstep_cmp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW),
                            .CNT_W(CNT_W), .STOP_ON_FAIL(1)) u_dut_halt (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_ch_mask(mask), .i_trace(trace_if),
      .o_cmp_count(hx_cmp), .o_mism_count(hx_mism), .o_err_mismatch(hx_emm), .o_err_timeout(hx_eto),
      .o_err_overflow(hx_eov), .o_fail_idx(hx_fidx), .o_fail_ch(hx_fch), .o_fail_ref(hx_fref),
      .o_fail_duv(hx_fduv), .o_halted(hx_halted));

   cpu_trace_lockstep_cmp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW),
                            .CNT_W(CNT_W), .STOP_ON_FAIL(0)) u_dut_run (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_ch_mask(mask), .i_trace(trace_if),
      .o_cmp_count(rx_cmp), .o_mism_count(rx_mism), .o_err_mismatch(rx_emm), .o_err_timeout(rx_eto),
      .o_err_overflow(rx_eov), .o_fail_idx(rx_fidx), .o_fail_ch(rx_fch), .o_fail_ref(rx_fref),
      .o_fail_duv(rx_fduv), .o_halted(rx_halted));

   int errors = 0;
   int checks = 0;
   logic [REC_W-1:0] ref_recs[$];
   logic [REC_W-1:0] duv_recs[$];
   int ref_off, duv_off;

   typedef struct packed {
      logic [CNT_W-1:0]  cmp_run;
      logic [CNT_W-1:0]  mism_run;
      logic [CNT_W-1:0]  cmp_halt;
      logic [CNT_W-1:0]  fidx;
      logic              any;
      logic [NUM_CH-1:0] fch;
      logic [REC_W-1:0]  fref;
      logic [REC_W-1:0]  fduv;
   } exp_t;

   // i-th reference record pairs with i-th DUV record regardless of arrival timing.
   function automatic exp_t model(input logic [NUM_CH-1:0] m);
      exp_t e;
      int n;
      logic [NUM_CH-1:0] d;
      logic [REC_W-1:0] rr, dd;
      e = '0;
      n = (ref_recs.size() < duv_recs.size()) ? ref_recs.size() : duv_recs.size();
      for (int i = 0; i < n; i++) begin
         rr = ref_recs[i];
         dd = duv_recs[i];
         d = '0;
         for (int k = 0; k < NUM_CH; k++)
            if (m[k] && (rr[k*DATA_W +: DATA_W] != dd[k*DATA_W +: DATA_W])) d[k] = 1'b1;
         if (d != '0) begin
            if (!e.any) begin
               e.any = 1'b1; e.fidx = CNT_W'(i); e.fch = d; e.fref = rr; e.fduv = dd;
               e.cmp_halt = CNT_W'(i + 1);
            end
            e.mism_run = e.mism_run + 1;
         end
      end
      e.cmp_run = CNT_W'(n);
      if (!e.any) e.cmp_halt = e.cmp_run;
      return e;
   endfunction

   function automatic logic [REC_W-1:0] rand_rec();
      logic [REC_W-1:0] r;
      for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      trace_if.ref_vld = 1'b0; trace_if.duv_vld = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0; en = 1'b1; tick();
   endtask

   task automatic fill_identical(input int n);
      logic [REC_W-1:0] r;
      ref_recs.delete(); duv_recs.delete();
      for (int i = 0; i < n; i++) begin
         r = rand_rec();
         ref_recs.push_back(r);
         duv_recs.push_back(r);
      end
   endtask

   task automatic drive_streams();
      int nr, nd, total;
      nr = ref_recs.size(); nd = duv_recs.size();
      total = (ref_off + nr > duv_off + nd) ? ref_off + nr : duv_off + nd;
      for (int c = 0; c < total; c++) begin
         trace_if.ref_vld = 1'b0; trace_if.ref_data = '0;
         trace_if.duv_vld = 1'b0; trace_if.duv_data = '0;
         if (c >= ref_off && c < ref_off + nr) begin
            trace_if.ref_vld = 1'b1; trace_if.ref_data = ref_recs[c - ref_off];
         end
         if (c >= duv_off && c < duv_off + nd) begin
            trace_if.duv_vld = 1'b1; trace_if.duv_data = duv_recs[c - duv_off];
         end
         tick();
      end
      trace_if.ref_vld = 1'b0; trace_if.duv_vld = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; clr = 1'b0; mask = '1;
      trace_if.ref_vld = 1'b0; trace_if.duv_vld = 1'b0;
      trace_if.ref_data = '0; trace_if.duv_data = '0;
      repeat (2) tick();
      rst = 1'b0;
      checks++; if (hx_all !== '0) begin errors++; $display("FAIL reset_halt_outputs: got %0h exp 0", hx_all); end
      checks++; if (rx_all !== '0) begin errors++; $display("FAIL reset_run_outputs: got %0h exp 0", rx_all); end
   endtask

   task automatic test_identical();
      exp_t e;
      start(); mask = '1; ref_off = 0; duv_off = 0;
      fill_identical(20); e = model(mask); drive_streams();
      checks++; if (rx_cmp !== e.cmp_run) begin errors++; $display("FAIL ident_cmp: got %0d exp %0d", rx_cmp, e.cmp_run); end
      checks++; if (rx_mism !== 0) begin errors++; $display("FAIL ident_mism: got %0d exp 0", rx_mism); end
      checks++; if ({rx_emm, rx_eto, rx_eov} !== 3'b000) begin errors++; $display("FAIL ident_flags: got %b exp 000", {rx_emm, rx_eto, rx_eov}); end
      checks++; if (hx_cmp !== e.cmp_run) begin errors++; $display("FAIL ident_halt_cmp: got %0d exp %0d", hx_cmp, e.cmp_run); end
   endtask

   task automatic test_lag();
      exp_t e;
      start(); mask = '1; ref_off = 0; duv_off = 5;
      fill_identical(20); e = model(mask); drive_streams();
      checks++; if (rx_cmp !== e.cmp_run) begin errors++; $display("FAIL lag_cmp: got %0d exp %0d", rx_cmp, e.cmp_run); end
      checks++; if ({rx_emm, rx_eto, rx_eov, hx_halted} !== 4'b0000) begin errors++; $display("FAIL lag_flags: got %b exp 0000", {rx_emm, rx_eto, rx_eov, hx_halted}); end
   endtask

   task automatic test_mismatch();
      exp_t e;
      logic [REC_W-1:0] r;
      start(); mask = '1; ref_off = 0; duv_off = 0;
      fill_identical(20);
      r = ref_recs[7]; r[2*DATA_W +: DATA_W] = 16'h0012; ref_recs[7] = r;
      r[2*DATA_W +: DATA_W] = 16'h0013; duv_recs[7] = r;
      e = model(mask); drive_streams();
      checks++; if (rx_emm !== 1'b1) begin errors++; $display("FAIL mism_flag: got %b exp 1", rx_emm); end
      checks++; if (rx_fidx !== 7) begin errors++; $display("FAIL mism_fail_idx: got %0d exp 7", rx_fidx); end
      checks++; if (rx_fch !== 6'b000100) begin errors++; $display("FAIL mism_fail_ch: got %b exp 000100", rx_fch); end
      checks++; if (rx_fref !== e.fref || rx_fduv !== e.fduv) begin errors++; $display("FAIL mism_capture: got %h/%h exp %h/%h", rx_fref, rx_fduv, e.fref, e.fduv); end
      checks++; if (rx_cmp !== 20 || rx_mism !== 1) begin errors++; $display("FAIL mism_run_counts: got %0d/%0d exp 20/1", rx_cmp, rx_mism); end
      checks++; if (hx_halted !== 1'b1) begin errors++; $display("FAIL mism_halted: got %b exp 1", hx_halted); end
      checks++; if (hx_cmp !== 8) begin errors++; $display("FAIL mism_halt_cmp: got %0d exp 8", hx_cmp); end
      checks++; if (rx_halted !== 1'b0) begin errors++; $display("FAIL mism_run_not_halted: got %b exp 0", rx_halted); end
   endtask

   task automatic test_masked();
      exp_t e;
      start(); mask = 6'b111011; ref_off = 0; duv_off = 0;
      e = model(mask); drive_streams();
      checks++; if (rx_emm !== e.any) begin errors++; $display("FAIL masked_flag: got %b exp %b", rx_emm, e.any); end
      checks++; if (rx_cmp !== 20 || hx_cmp !== 20) begin errors++; $display("FAIL masked_cmp: got %0d/%0d exp 20/20", rx_cmp, hx_cmp); end
      checks++; if (hx_halted !== 1'b0) begin errors++; $display("FAIL masked_halted: got %b exp 0", hx_halted); end
   endtask

   task automatic test_random();
      exp_t e;
      logic [REC_W-1:0] r;
      int n, lag, nerr, idx, bitpos;
      for (int it = 0; it < 6; it++) begin
         start();
         mask = NUM_CH'($urandom);
         n = $urandom_range(10, 20);
         lag = $urandom_range(0, 6);
         if ($urandom_range(0, 1) == 1) begin ref_off = lag; duv_off = 0; end
         else begin ref_off = 0; duv_off = lag; end
         fill_identical(n);
         nerr = $urandom_range(0, 3);
         for (int j = 0; j < nerr; j++) begin
            idx = $urandom_range(0, n - 1);
            bitpos = $urandom_range(0, REC_W - 1);
            r = duv_recs[idx]; r[bitpos] = ~r[bitpos]; duv_recs[idx] = r;
         end
         e = model(mask); drive_streams();
         checks++; if (rx_cmp !== e.cmp_run || rx_mism !== e.mism_run) begin errors++; $display("FAIL rand%0d_run_counts: got %0d/%0d exp %0d/%0d", it, rx_cmp, rx_mism, e.cmp_run, e.mism_run); end
         checks++; if (rx_emm !== e.any || rx_fidx !== e.fidx || rx_fch !== e.fch) begin errors++; $display("FAIL rand%0d_capture: got %b/%0d/%b exp %b/%0d/%b", it, rx_emm, rx_fidx, rx_fch, e.any, e.fidx, e.fch); end
         checks++; if (rx_fref !== e.fref || rx_fduv !== e.fduv) begin errors++; $display("FAIL rand%0d_records: got %h/%h exp %h/%h", it, rx_fref, rx_fduv, e.fref, e.fduv); end
         checks++; if (hx_cmp !== e.cmp_halt || hx_halted !== e.any) begin errors++; $display("FAIL rand%0d_halt: got %0d/%b exp %0d/%b", it, hx_cmp, hx_halted, e.cmp_halt, e.any); end
         checks++; if ({rx_eto, rx_eov} !== 2'b00) begin errors++; $display("FAIL rand%0d_skew_flags: got %b exp 00", it, {rx_eto, rx_eov}); end
      end
   endtask

   task automatic test_overflow_timeout();
      start(); mask = '1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         trace_if.ref_vld = 1'b1; trace_if.ref_data = rand_rec();
         tick();
         if (i == DEPTH - 1) begin
            checks++; if (rx_eov !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", rx_eov); end
         end
      end
      trace_if.ref_vld = 1'b0;
      checks++; if (rx_eov !== 1'b1 || hx_eov !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b/%b exp 1/1", rx_eov, hx_eov); end
      checks++; if (hx_halted !== 1'b1 || rx_halted !== 1'b0) begin errors++; $display("FAIL ovf_halt: got %b/%b exp 1/0", hx_halted, rx_halted); end
      repeat (MAX_SKEW - (DEPTH + 1)) tick();
      checks++; if (rx_eto !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b exp 0", rx_eto); end
      tick();
      checks++; if (rx_eto !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b exp 1", rx_eto); end
      checks++; if (hx_eto !== 1'b0 || rx_cmp !== 0) begin errors++; $display("FAIL tmo_frozen: got %b/%0d exp 0/0", hx_eto, rx_cmp); end
   endtask

   task automatic test_rst_clr_midstream();
      exp_t e;
      logic [REC_W-1:0] r;
      start(); mask = '1;
      for (int i = 0; i < 3; i++) begin trace_if.ref_vld = 1'b1; trace_if.ref_data = rand_rec(); tick(); end
      trace_if.ref_vld = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (rx_all !== '0 || hx_all !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %0h/%0h exp 0", rx_all, hx_all); end
      tick();
      ref_off = 0; duv_off = 0; fill_identical(10);
      r = duv_recs[2]; r[4*DATA_W] = ~r[4*DATA_W]; duv_recs[2] = r;
      e = model(mask); drive_streams();
      checks++; if (rx_cmp !== e.cmp_run || rx_fidx !== 2 || rx_fch !== 6'b010000) begin errors++; $display("FAIL rst_restart: got %0d/%0d/%b exp %0d/2/010000", rx_cmp, rx_fidx, rx_fch, e.cmp_run); end
      checks++; if (hx_cmp !== 3) begin errors++; $display("FAIL rst_restart_halt_cmp: got %0d exp 3", hx_cmp); end

      start();
      for (int i = 0; i < 3; i++) begin trace_if.ref_vld = 1'b1; trace_if.ref_data = rand_rec(); tick(); end
      clr = 1'b1; tick(); clr = 1'b0; trace_if.ref_vld = 1'b0;
      checks++; if (rx_all !== '0 || hx_all !== '0) begin errors++; $display("FAIL clr_mid_outputs: got %0h/%0h exp 0", rx_all, hx_all); end
      tick();
      fill_identical(10); e = model(mask); drive_streams();
      checks++; if (rx_cmp !== e.cmp_run || rx_mism !== 0 || rx_emm !== 1'b0) begin errors++; $display("FAIL clr_restart: got %0d/%0d/%b exp %0d/0/0", rx_cmp, rx_mism, rx_emm, e.cmp_run); end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_lag();
      test_mismatch();
      test_masked();
      test_random();
      test_overflow_timeout();
      test_rst_clr_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
